pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipelined CPU (IF, ID, EX, MEM, WB).
- Detects load-use hazards that forwarding cannot cover and inserts a bubble.
- Squashes wrong-path instructions when a branch resolves taken in MEM.
- Freezes the whole pipeline while a multi-cycle data memory access is outstanding.
- Drives the enable and flush inputs of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers, and exposes stall/flush performance counters.

Parameters:
- CNT_W, 32: width of the performance counters.
- MEM_TIMEOUT, 64: maximum consecutive memory-wait cycles before the error trap.
- WAIT_W, 8: width of the wait counter; must satisfy 2**WAIT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rn_if_id  in  5  Rn field of the instruction in ID.
- rm_if_id  in  5  second source register of the instruction in ID (Reg2Loc-muxed).
- uses_rm_if_id  in  1  ID instruction reads rm_if_id.
- rd_id_ex  in  5  destination of the instruction in EX.
- memread_id_ex  in  1  instruction in EX is a load.
- branch_taken_mem  in  1  branch resolved taken in MEM.
- dmem_req  in  1  MEM-stage instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all controls 0) on the next edge.
- state  out  2  current FSM state.
- stall_cnt  out  CNT_W  bubble and freeze cycles.
- flush_cnt  out  CNT_W  taken-branch flush events.
- mem_timeout_err  out  1  sticky error flag.

Behaviour:
- State, counters and error flag are registers. Enables and flushes are combinational from the state and current inputs.

Reset (rst asserted):
- state=RUN; stall_cnt, flush_cnt, wait counter and mem_timeout_err = 0.
- All enables 1, all flushes 0, regardless of the other inputs.

Hazard and event definitions:
- load_use = memread_id_ex && rd_id_ex!=5'd31 && (rd_id_ex==rn_if_id || (uses_rm_if_id && rd_id_ex==rm_if_id)).
- X31 (XZR) never creates a hazard.
- freeze = dmem_req && !dmem_ready.

Priority in RUN:
1. freeze: all enables 0, flushes 0; stall_cnt+1; next state MEMWAIT; wait counter set to 1.
2. branch_taken_mem: all enables 1, ifid_flush, idex_flush and exmem_flush = 1; flush_cnt+1.
   - The PC loads the target supplied by the datapath.
   - A simultaneous load_use is ignored, because the hazarding instruction is squashed.
3. load_use: pc_en=0, ifid_en=0, idex_flush=1, other enables 1; stall_cnt+1.
   - The hazard clears on the following cycle because the load advances to MEM, so the bubble is exactly 1 cycle.
4. Otherwise: all enables 1, flushes 0.

MEMWAIT:
- While !dmem_ready: all enables 0; stall_cnt+1; wait counter+1.
- When dmem_ready=1: leave the freeze this cycle and return to RUN. The RUN priority rules 2–4 apply in this same cycle.
  - branch_taken_mem stays stable during the freeze because EX_MEM is frozen, so a taken branch in the frozen instruction flushes on the release cycle.
- If the wait counter reaches MEM_TIMEOUT with dmem_ready still 0: next state ERROR, and mem_timeout_err is set.

ERROR:
- All enables 0, flushes 0. Counters hold.
- Exit only via rst.

General rules:
- Counters saturate at all-ones; no wrap.
- Reset asserted mid-freeze or mid-stall takes effect immediately (asynchronous).
- State encoding: RUN=0, MEMWAIT=1, ERROR=2; 3 is unreachable and is decoded as ERROR.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - ctrl_state_t enum {RUN, MEMWAIT, ERROR};
  - XZR_IDX = 5'd31;
  - struct pipe_ctrl_t bundling the 5 enables and 3 flushes.
- Sub-module hazard_detect: purely combinational load_use compare, reused later for a stall-based branch variant. The FSM and counters stay in pipeline_ctrl.

Test Plan:
- LDUR X1 at EX (rd=1, memread=1), ADD in ID with rn=1 → exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0→1; the next cycle is all enables 1.
- Same stimulus with rd_id_ex=31 → no stall; stall_cnt stays 0.
- branch_taken_mem=1 for one cycle with load_use also true → ifid_flush, idex_flush and exmem_flush =1, pc_en=1, no stall; flush_cnt=1, stall_cnt=0.
- dmem_req=1, dmem_ready=0 for 3 cycles, then ready → enables 0 for 3 cycles and 1 on the 4th; state RUN→MEMWAIT→RUN; stall_cnt=3.
- dmem_req=1, dmem_ready held 0 with MEM_TIMEOUT=4 → state=ERROR and mem_timeout_err=1 after 4 wait cycles; stays there until rst=1, which clears everything asynchronously without a clock edge.
- Freeze with branch_taken_mem=1 held, then dmem_ready=1 → flushes asserted only on the release cycle; flush_cnt increments once.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// Register-enable/flush bundle, FSM states and fixed control words.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERROR   = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] XZR_IDX = 5'd31;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN    = 8'b11111_000;
  localparam pipe_ctrl_t CTRL_HOLD   = 8'b00000_000;
  localparam pipe_ctrl_t CTRL_BUBBLE = 8'b00111_010;
  localparam pipe_ctrl_t CTRL_FLUSH  = 8'b11111_111;

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// Load-use hazard compare between the ID operands and the EX load.
// Purely combinational; XZR never hazards.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] i_rn,
  input  logic [4:0] i_rm,
  input  logic       i_uses_rm,
  input  logic [4:0] i_rd,
  input  logic       i_memread,
  output logic       o_load_use
);

  logic w_rn_hit;
  logic w_rm_hit;

  assign w_rn_hit   = (i_rd == i_rn);
  assign w_rm_hit   = i_uses_rm && (i_rd == i_rm);
  assign o_load_use = i_memread && (i_rd != XZR_IDX) &&
                      (w_rn_hit || w_rm_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Handles load-use bubbles, taken-branch squash and memory freeze.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64,
  parameter int WAIT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rn_if_id,
  input  logic [4:0]       rm_if_id,
  input  logic             uses_rm_if_id,
  input  logic [4:0]       rd_id_ex,
  input  logic             memread_id_ex,
  input  logic             branch_taken_mem,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout_err
);

  localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MEM_TIMEOUT);
  localparam logic              TMO_NOW = (MEM_TIMEOUT <= 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [WAIT_W-1:0] w_wait_inc;
  logic [CNT_W-1:0]  r_stall;
  logic [CNT_W-1:0]  r_flush;
  logic              r_err;
  logic              w_load_use;
  logic              w_freeze;
  logic              w_run;
  logic              w_stall;
  logic              w_flush;
  logic              w_err_set;
  pipe_ctrl_t        w_ctrl;

  hazard_detect u_hazard (
    .i_rn       (rn_if_id),
    .i_rm       (rm_if_id),
    .i_uses_rm  (uses_rm_if_id),
    .i_rd       (rd_id_ex),
    .i_memread  (memread_id_ex),
    .o_load_use (w_load_use)
  );

  assign w_freeze   = dmem_req && !dmem_ready;
  assign w_wait_inc = r_wait + WAIT_W'(1);

  always_comb begin
    w_ctrl     = CTRL_RUN;
    w_nxt      = r_state;
    w_wait_nxt = r_wait;
    w_run      = 1'b0;
    w_stall    = 1'b0;
    w_flush    = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      RUN: begin
        if (w_freeze) begin
          w_ctrl     = CTRL_HOLD;
          w_stall    = 1'b1;
          w_wait_nxt = WAIT_W'(1);
          w_nxt      = TMO_NOW ? ERROR : MEMWAIT;
          w_err_set  = TMO_NOW;
        end else begin
          w_run = 1'b1;
        end
      end
      MEMWAIT: begin
        if (!dmem_ready) begin
          w_ctrl     = CTRL_HOLD;
          w_stall    = 1'b1;
          w_wait_nxt = w_wait_inc;
          if (w_wait_inc >= TMO) begin
            w_nxt     = ERROR;
            w_err_set = 1'b1;
          end
        end else begin
          w_run      = 1'b1;
          w_nxt      = RUN;
          w_wait_nxt = '0;
        end
      end
      default: begin
        w_ctrl = CTRL_HOLD;
        w_nxt  = ERROR;
      end
    endcase
    // Release cycle of a freeze shares the normal RUN priorities.
    if (w_run) begin
      if (branch_taken_mem) begin
        w_ctrl  = CTRL_FLUSH;
        w_flush = 1'b1;
      end else if (w_load_use) begin
        w_ctrl  = CTRL_BUBBLE;
        w_stall = 1'b1;
      end
    end
    if (rst) w_ctrl = CTRL_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_wait  <= '0;
      r_stall <= '0;
      r_flush <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_wait  <= w_wait_nxt;
      if (w_stall && !(&r_stall)) r_stall <= r_stall + CNT_W'(1);
      if (w_flush && !(&r_flush)) r_flush <= r_flush + CNT_W'(1);
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign pc_en           = w_ctrl.pc_en;
  assign ifid_en         = w_ctrl.ifid_en;
  assign idex_en         = w_ctrl.idex_en;
  assign exmem_en        = w_ctrl.exmem_en;
  assign memwb_en        = w_ctrl.memwb_en;
  assign ifid_flush      = w_ctrl.ifid_flush;
  assign idex_flush      = w_ctrl.idex_flush;
  assign exmem_flush     = w_ctrl.exmem_flush;
  assign state           = r_state;
  assign stall_cnt       = r_stall;
  assign flush_cnt       = r_flush;
  assign mem_timeout_err = r_err;

endmodule
